dma_read_master: RTL and testbench

Sequential read master that sits directly upstream of a device arbiter port. Given a bank, start address and word count, it issues pipelined 32-bit read requests, honours the arbiter's combinational `busy` back-pressure and its in-order `ack` returns, and buffers returned words in an internal FIFO. The FIFO is drained through a valid/ready stream toward the consumer (e.g. USB/PI data path). Outstanding reads are credit-limited so that every acked word always has buffer space.

---
 rtl/dma_read_master_if.sv | 23 ++
 rtl/dma_read_master.sv | 91 +++++++++
 tb/tb_dma_read_master.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/dma_read_master_if.sv
// dma_read_master_if: arbiter read port plus receive stream seen by the read master.
interface dma_read_master_if #(
  parameter int ADDRESS_WIDTH = 26
);
  logic                     o_request;
  logic                     o_write;
  logic                     i_busy;
  logic                     i_ack;
  logic [3:0]               o_bank;
  logic [ADDRESS_WIDTH-1:0] o_address;
  logic [31:0]              i_data;
  logic                     o_rx_valid;
  logic [31:0]              o_rx_data;
  logic                     i_rx_ready;
  modport master (
    output o_request, o_write, o_bank, o_address, o_rx_valid, o_rx_data,
    input  i_busy, i_ack, i_data, i_rx_ready
  );
  modport slave (
    input  o_request, o_write, o_bank, o_address, o_rx_valid, o_rx_data,
    output i_busy, i_ack, i_data, i_rx_ready
  );
endinterface

// File: rtl/dma_read_master.sv
// dma_read_master: credit-limited pipelined read master with a show-ahead receive FIFO.
module dma_read_master #(
  parameter int ADDRESS_WIDTH = 26,
  parameter int LENGTH_WIDTH  = 16,
  parameter int BUFFER_DEPTH  = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_start,
  input  logic                     i_stop,
  input  logic [3:0]               i_bank,
  input  logic [ADDRESS_WIDTH-1:0] i_address,
  input  logic [LENGTH_WIDTH-1:0]  i_length,
  output logic                     o_active,
  output logic                     o_done,
  dma_read_master_if.master        bus
);
  localparam int PW = $clog2(BUFFER_DEPTH);
  localparam int CW = PW + 1;
  typedef enum logic [1:0] {IDLE, ISSUE, FLUSH} state_t;
  state_t                   state_q;
  logic [LENGTH_WIDTH-1:0]  remaining_q, remaining_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic [3:0]               bank_q;
  logic [CW-1:0]            outstanding_q, outstanding_d, level_q, level_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]              mem_q [BUFFER_DEPTH];
  logic                     zero_done_q, launch, accept, ack_ok, push, pop, stop, complete;

  assign launch   = state_q == IDLE && i_start;
  assign accept   = bus.o_request && !bus.i_busy;
  assign ack_ok   = bus.i_ack && outstanding_q != '0;
  assign push     = ack_ok && state_q == ISSUE;
  assign pop      = bus.o_rx_valid && bus.i_rx_ready;
  assign stop     = state_q == ISSUE && i_stop;
  assign complete = state_q == ISSUE && remaining_q == '0 && outstanding_q == '0 && level_q == '0;

  // Credit: a request only goes out if its returning word is guaranteed a FIFO slot.
  assign bus.o_request  = state_q == ISSUE && remaining_q != '0 &&
                          ({1'b0, outstanding_q} + {1'b0, level_q}) < (CW+1)'(BUFFER_DEPTH);
  assign bus.o_write    = 1'b0;
  assign bus.o_bank     = bank_q;
  assign bus.o_address  = address_q;
  assign bus.o_rx_valid = level_q != '0;
  assign bus.o_rx_data  = mem_q[rd_ptr_q];
  assign o_active       = state_q != IDLE;
  assign o_done         = zero_done_q || (complete && !i_stop);

  always_comb begin
    remaining_d   = launch ? i_length : remaining_q - LENGTH_WIDTH'(accept);
    address_d     = launch ? (i_address & ~ADDRESS_WIDTH'(3))
                           : address_q + (accept ? ADDRESS_WIDTH'(4) : '0);
    outstanding_d = outstanding_q + CW'(accept) - CW'(ack_ok);
    level_d       = stop ? '0 : level_q + CW'(push) - CW'(pop);
    wr_ptr_d      = stop ? '0 : wr_ptr_q + PW'(push);
    rd_ptr_d      = stop ? '0 : rd_ptr_q + PW'(pop);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q       <= IDLE;
      remaining_q   <= '0;
      address_q     <= '0;
      bank_q        <= '0;
      outstanding_q <= '0;
      level_q       <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      zero_done_q   <= 1'b0;
    end else begin
      remaining_q   <= remaining_d;
      address_q     <= address_d;
      outstanding_q <= outstanding_d;
      level_q       <= level_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      zero_done_q   <= launch && i_length == '0;
      if (launch) bank_q <= i_bank;
      case (state_q)
        IDLE:    state_q <= (launch && i_length != '0) ? ISSUE : IDLE;
        ISSUE:   state_q <= stop ? FLUSH : complete ? IDLE : ISSUE;
        FLUSH:   state_q <= outstanding_q == '0 ? IDLE : FLUSH;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.i_data;
  end
endmodule

// File: tb/tb_dma_read_master.sv
// tb_dma_read_master: directed scoreboard bench with a fixed-latency arbiter model.
module tb_dma_read_master;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, active, done;
  logic [3:0]  bank;
  logic [25:0] address;
  logic [15:0] length;

  always #5 clk = ~clk;

  dma_read_master_if #(.ADDRESS_WIDTH(26)) bus();

  dma_read_master #(.ADDRESS_WIDTH(26), .LENGTH_WIDTH(16), .BUFFER_DEPTH(8)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_start(start), .i_stop(stop),
    .i_bank(bank), .i_address(address), .i_length(length),
    .o_active(active), .o_done(done), .bus(bus)
  );

  int compared = 0, mismatched = 0;
  int cyc = 0, accepts = 0, done_cnt = 0, man_acks = 0, done_cyc = 0, last_pop = 0;
  bit auto_ack = 1'b1, acc_pend = 1'b0;
  logic [25:0] acc_addr;
  logic [31:0] exp_req[$], exp_data[$];
  typedef struct {logic [25:0] a; int due;} pend_t;
  pend_t pend[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expected requests and words whenever the DUT presents them.
  always @(negedge clk) begin
    acc_pend = 1'b0;
    if (rst_n) begin
      if (bus.o_request && !bus.i_busy) begin
        accepts++;
        acc_pend = 1'b1;
        acc_addr = bus.o_address;
        check("req_expected", 32'(exp_req.size() != 0), 1);
        if (exp_req.size() != 0) check("req_bank_addr", {bus.o_bank, 2'b00, bus.o_address}, exp_req.pop_front());
      end
      if (bus.o_rx_valid && bus.i_rx_ready) begin
        last_pop = cyc;
        check("data_expected", 32'(exp_data.size() != 0), 1);
        if (exp_data.size() != 0) check("rx_data", bus.o_rx_data, exp_data.pop_front());
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  // Arbiter model: in-order acks, two cycles after acceptance or on manual demand.
  always begin
    @(posedge clk);
    #1;
    if (acc_pend) pend.push_back('{acc_addr, cyc + 1});
    bus.i_ack = 1'b0;
    if (pend.size() != 0 && (auto_ack ? pend[0].due <= cyc : man_acks > 0)) begin
      bus.i_ack  = 1'b1;
      bus.i_data = {6'h2A, pend[0].a};
      void'(pend.pop_front());
      if (!auto_ack) man_acks--;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic launch(logic [3:0] b, logic [25:0] a, logic [15:0] l);
    bank = b; address = a; length = l; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(string name, int budget);
    int d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    check(name, 32'(done_cnt - d0), 1);
  endtask

  task automatic expect_run(logic [3:0] b, logic [25:0] a, int n, bit with_data);
    for (int i = 0; i < n; i++) begin
      exp_req.push_back({b, 2'b00, a + 26'(4 * i)});
      if (with_data) exp_data.push_back({6'h2A, a + 26'(4 * i)});
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, d0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; bank = '0; address = '0; length = '0;
    bus.i_busy = 1'b0; bus.i_ack = 1'b0; bus.i_data = '0; bus.i_rx_ready = 1'b1;
    tick(3);
    check("rst_active", active, 0);
    check("rst_done", done, 0);
    check("rst_request", bus.o_request, 0);
    check("rst_rx_valid", bus.o_rx_valid, 0);
    check("rst_address", bus.o_address, 0);
    check("rst_bank", bus.o_bank, 0);
    check("rst_write", bus.o_write, 0);
    rst_n = 1'b1;
    tick();

    // Basic 4-word transfer
    exp_req = '{32'h1000_0100, 32'h1000_0104, 32'h1000_0108, 32'h1000_010C};
    exp_data = '{32'hA800_0100, 32'hA800_0104, 32'hA800_0108, 32'hA800_010C};
    launch(4'h1, 26'h100, 16'd4);
    check("t1_first_req", bus.o_request, 1);
    check("t1_first_addr", bus.o_address, 32'h100);
    wait_done("t1_done", 60);
    check("t1_done_after_pop", 32'(done_cyc - last_pop), 1);
    check("t1_bank", bus.o_bank, 1);
    check("t1_idle", active, 0);

    // Credit limit with a stalled consumer
    expect_run(4'h2, 26'h0, 12, 1'b1);
    bus.i_rx_ready = 1'b0;
    a0 = accepts;
    launch(4'h2, 26'h0, 16'd12);
    tick(20);
    check("t2_credit_accepts", 32'(accepts - a0), 8);
    check("t2_req_low", bus.o_request, 0);
    check("t2_rx_valid", bus.o_rx_valid, 1);
    check("t2_head", bus.o_rx_data, 32'hA800_0000);
    bus.i_rx_ready = 1'b1;
    wait_done("t2_done", 120);
    check("t2_accepts", 32'(accepts - a0), 12);

    // Busy back-pressure on the second request
    expect_run(4'h3, 26'h0, 3, 1'b1);
    a0 = accepts;
    launch(4'h3, 26'h0, 16'd3);
    tick();
    bus.i_busy = 1'b1;
    repeat (3) begin
      check("t3_hold_req", bus.o_request, 1);
      check("t3_hold_addr", bus.o_address, 32'h4);
      tick();
    end
    bus.i_busy = 1'b0;
    wait_done("t3_done", 60);
    check("t3_accepts", 32'(accepts - a0), 3);

    // Address wrap at the top of the space
    exp_req = '{32'h43FF_FFFC, 32'h4000_0000};
    exp_data = '{32'hABFF_FFFC, 32'hA800_0000};
    launch(4'h4, 26'h3FF_FFFC, 16'd2);
    tick();
    check("t4_wrap_addr", bus.o_address, 32'h0);
    wait_done("t4_done", 60);

    // Abort with 3 outstanding and 2 buffered
    expect_run(4'h5, 26'h200, 5, 1'b0);
    auto_ack = 1'b0;
    bus.i_rx_ready = 1'b0;
    a0 = accepts;
    d0 = done_cnt;
    launch(4'h5, 26'h200, 16'd5);
    tick(6);
    check("t5_accepts", 32'(accepts - a0), 5);
    man_acks = 2;
    tick(4);
    check("t5_buffered_valid", bus.o_rx_valid, 1);
    check("t5_buffered_head", bus.o_rx_data, 32'hA800_0200);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("t5_flush_rx", bus.o_rx_valid, 0);
    check("t5_flush_active", active, 1);
    check("t5_flush_req", bus.o_request, 0);
    man_acks = 3;
    for (int i = 0; i < 12 && active; i++) tick();
    check("t5_idle", active, 0);
    check("t5_acks_swallowed", 32'(pend.size()), 0);
    check("t5_no_done", 32'(done_cnt - d0), 0);
    auto_ack = 1'b1;
    bus.i_rx_ready = 1'b1;
    expect_run(4'h6, 26'h40, 2, 1'b1);
    launch(4'h6, 26'h40, 16'd2);
    wait_done("t5_restart_done", 60);

    // Zero length
    a0 = accepts;
    d0 = done_cnt;
    launch(4'h0, 26'h0, 16'd0);
    check("t6_done_pulse", done, 1);
    check("t6_inactive", active, 0);
    check("t6_no_req", bus.o_request, 0);
    tick();
    check("t6_done_end", done, 0);
    check("t6_done_count", 32'(done_cnt - d0), 1);
    check("t6_accepts", 32'(accepts - a0), 0);

    // Start while active is ignored; low address bits are dropped
    expect_run(4'h7, 26'h80, 5, 1'b1);
    a0 = accepts;
    launch(4'h7, 26'h83, 16'd5);
    tick();
    bank = 4'h9; address = 26'h500; length = 16'd3; start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t7_done", 60);
    check("t7_accepts", 32'(accepts - a0), 5);
    check("t7_bank", bus.o_bank, 7);

    tick(4);
    check("req_queue_empty", 32'(exp_req.size()), 0);
    check("data_queue_empty", 32'(exp_data.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
